// File: rtl/sched_pkg.sv
// Shared types and sizes for the sort-engine job scheduler.
package sched_pkg;
  localparam int ELEM_W   = 4;
  localparam int RES_W    = 6;
  localparam int NUM_ELEM = 4;
  localparam int MODE_W   = 2;
  localparam int DATA_W   = ELEM_W * NUM_ELEM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or after ptr, cyclically.
module rr_arbiter
  import sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any_grant
);
  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDX_W'((int'(ptr) + i) % NREQ);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/sort_job_scheduler.sv
// Shares one serial sort/compute engine among NREQ requesters: round-robin job grant,
// 4-beat feed, result wait with timeout, and a tagged response held until accepted.
module sort_job_scheduler
  import sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 100
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [MODE_W*NREQ-1:0]      req_mode,
  input  logic [DATA_W*NREQ-1:0]      req_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NREQ)-1:0]     rsp_id,
  output logic signed [RES_W-1:0]     rsp_result,
  output logic                        rsp_err,
  output logic                        eng_in_valid,
  output logic signed [ELEM_W-1:0]    eng_in_number,
  output logic [MODE_W-1:0]           eng_mode,
  input  logic                        eng_out_valid,
  input  logic signed [RES_W-1:0]     eng_out_result,
  output logic                        spurious,
  output state_t                      dbg_state
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  // Handshakes: a request transfers on the edge where req_valid[i] & req_ready[i];
  // a response transfers on the edge where rsp_valid & rsp_ready. Valid never waits on ready.

  state_t                   state, state_n;
  logic [IDX_W-1:0]         ptr;
  logic [1:0]               beat;
  logic [TMO_W-1:0]         tmo_cnt;
  logic [MODE_W-1:0]        job_mode;
  logic [DATA_W-1:0]        job_data;
  logic [IDX_W-1:0]         res_id;
  logic signed [RES_W-1:0]  res_val;
  logic                     res_err;
  logic                     spurious_q;

  logic [NREQ-1:0]          grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     any_grant;
  logic                     tmo_hit;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_grant) state_n = FEED;
      FEED:    if (beat == 2'(NUM_ELEM - 1)) state_n = WAIT;
      WAIT:    if (eng_out_valid || tmo_hit) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Grant is only offered from IDLE, so RESP back-pressure also stalls new jobs.
  always_comb begin
    req_ready     = '0;
    eng_in_valid  = 1'b0;
    eng_in_number = '0;
    eng_mode      = '0;
    rsp_valid     = 1'b0;
    rsp_id        = '0;
    rsp_result    = '0;
    rsp_err       = 1'b0;
    if (state == IDLE && !rst) req_ready = grant;
    if (state == FEED) begin
      eng_in_valid  = 1'b1;
      eng_in_number = job_data[ELEM_W*int'(beat) +: ELEM_W];
      eng_mode      = job_mode;
    end
    if (state == RESP) begin
      rsp_valid  = 1'b1;
      rsp_id     = res_id;
      rsp_result = res_val;
      rsp_err    = res_err;
    end
  end

  assign spurious  = spurious_q;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      beat       <= '0;
      tmo_cnt    <= '0;
      job_mode   <= '0;
      job_data   <= '0;
      res_id     <= '0;
      res_val    <= '0;
      res_err    <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state <= state_n;
      if (eng_out_valid && state != WAIT) spurious_q <= 1'b1;
      case (state)
        IDLE: begin
          if (any_grant) begin
            job_mode <= req_mode[MODE_W*int'(grant_idx) +: MODE_W];
            job_data <= req_data[DATA_W*int'(grant_idx) +: DATA_W];
            res_id   <= grant_idx;
            ptr      <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            beat     <= '0;
            tmo_cnt  <= '0;
          end
        end
        FEED: beat <= beat + 2'd1;
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // An answer arriving on the last allowed cycle still wins over the timeout.
          if (eng_out_valid) begin
            res_val <= eng_out_result;
            res_err <= 1'b0;
          end else if (tmo_hit) begin
            res_val <= '0;
            res_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
